// File: rtl/charlieplex_scanner.sv
// charlieplex_scanner: time-multiplexes a double-buffered LED frame bitmap
// onto a charlieplexer decoder, one LED per slot (blanking gap, then dwell).
// Optional build macro SKIP_DARK_EN: dark LEDs take a single-cycle slot.
module charlieplex_scanner #(
    parameter  int PINCOUNT     = 4,
    parameter  int DWELL_CYCLES = 1000,
    parameter  int BLANK_CYCLES = 4,
    localparam int LEDCOUNT     = PINCOUNT * (PINCOUNT - 1),
    localparam int INDEXBITS    = $clog2(LEDCOUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [LEDCOUNT-1:0]  frame_data,
    input  logic                 frame_load,
    output logic                 pending,
    output logic [INDEXBITS-1:0] led_index,
    output logic                 led_enable,
    output logic                 frame_done
);

    localparam int MAXCYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TIMERBITS = $clog2(MAXCYCLES + 1);

    localparam logic [TIMERBITS-1:0] BLANK_LAST = TIMERBITS'(BLANK_CYCLES - 1);
    localparam logic [TIMERBITS-1:0] DWELL_LAST = TIMERBITS'(DWELL_CYCLES - 1);
    localparam logic [INDEXBITS-1:0] IDX_LAST   = INDEXBITS'(LEDCOUNT - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [TIMERBITS-1:0] timer, timer_next;
    logic [INDEXBITS-1:0] idx, idx_next;
    logic [LEDCOUNT-1:0]  shadow;
    logic [LEDCOUNT-1:0]  buffer;
    logic                 wrap;
    logic                 enable_next;

    // Next-state logic: slot timing, index advance and wrap detection
    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = idx;
        wrap       = 1'b0;
        if (!run) begin
            state_next = ST_BLANK;
            timer_next = '0;
            idx_next   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
`ifdef SKIP_DARK_EN
                    if (!shadow[idx]) begin
                        // Dark LED: this single blank cycle is its whole slot
                        timer_next = '0;
                        wrap       = (idx == IDX_LAST);
                        idx_next   = wrap ? '0 : idx + 1'b1;
                    end else
`endif
                    if (timer == BLANK_LAST) begin
                        state_next = ST_ON;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                ST_ON: begin
                    if (timer == DWELL_LAST) begin
                        state_next = ST_BLANK;
                        timer_next = '0;
                        wrap       = (idx == IDX_LAST);
                        idx_next   = wrap ? '0 : idx + 1'b1;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_BLANK;
                    timer_next = '0;
                end
            endcase
        end
        // Shadow only changes on a wrap, which always lands in BLANK,
        // so the current shadow is valid for any ON entry
        enable_next = (state_next == ST_ON) && shadow[idx_next];
    end

    // State register with outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            timer      <= '0;
            idx        <= '0;
            led_index  <= '0;
            led_enable <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            idx        <= idx_next;
            led_index  <= idx_next;
            led_enable <= enable_next;
            frame_done <= wrap;
        end
    end

    // Frame double buffer: loads go to the pending buffer, and the shadow
    // is only refreshed on the wrap edge so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            buffer  <= '0;
            pending <= 1'b0;
        end else if (wrap) begin
            if (frame_load) begin
                shadow <= frame_data;
            end else if (pending) begin
                shadow <= buffer;
            end
            pending <= 1'b0;
        end else if (frame_load) begin
            buffer  <= frame_data;
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Self-checking bench for charlieplex_scanner (PINCOUNT=3, DWELL=4, BLANK=2).
`timescale 1ns/1ps
module tb_charlieplex_scanner;

    localparam int P = 3;
    localparam int L = P * (P - 1);
    localparam int D = 4;
    localparam int B = 2;

    logic         clk;
    logic         rst_n;
    logic         run;
    logic [L-1:0] frame_data;
    logic         frame_load;
    logic         pending;
    logic [2:0]   led_index;
    logic         led_enable;
    logic         frame_done;

    int n_cmp = 0;
    int n_err = 0;

    charlieplex_scanner #(
        .PINCOUNT    (P),
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .frame_data(frame_data),
        .frame_load(frame_load),
        .pending   (pending),
        .led_index (led_index),
        .led_enable(led_enable),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: slot position plus frame buffers
    int         m_idx, m_cyc;
    logic [L-1:0] m_shadow, m_buf;
    bit         m_pend, m_done;
    bit         model_on = 0;

    function automatic int slot_len();
`ifdef SKIP_DARK_EN
        return m_shadow[m_idx] ? (B + D) : 1;
`else
        return B + D;
`endif
    endfunction

    task automatic model_reset();
        m_idx = 0; m_cyc = 0; m_shadow = '0; m_buf = '0; m_pend = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit r, input bit ld, input logic [L-1:0] d);
        bit w;
        w = 0;
        if (!r) begin
            m_idx = 0;
            m_cyc = 0;
        end else if (m_cyc == slot_len() - 1) begin
            w = (m_idx == L - 1);
            m_cyc = 0;
            m_idx = (m_idx + 1) % L;
        end else begin
            m_cyc++;
        end
        if (w) begin
            if (ld) m_shadow = d;
            else if (m_pend) m_shadow = m_buf;
            m_pend = 0;
        end else if (ld) begin
            m_buf = d;
            m_pend = 1;
        end
        m_done = w;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m_index",   32'(led_index),  32'(m_idx));
        chk("m_enable",  32'(led_enable), 32'((m_cyc >= B) && m_shadow[m_idx]));
        chk("m_pending", 32'(pending),    32'(m_pend));
        chk("m_done",    32'(frame_done), 32'(m_done));
    endtask

    // Entered on a falling edge; drives inputs, clocks once, samples at next falling edge
    task automatic tick(input bit r, input bit ld, input logic [L-1:0] d);
        run = r; frame_load = ld; frame_data = d;
        @(posedge clk);
        model_edge(r, ld, d);
        @(negedge clk);
        if (model_on) check_model();
    endtask

    typedef struct {
        bit           run;
        bit           load;
        logic [L-1:0] data;
        int           cycles;
        int           e_idx;
        bit           e_en;
        bit           e_pend;
        bit           e_done;
    } vec_t;

    vec_t vecs[29];

    initial begin
        int lit;
        int tick_done;
        bit near_wrap, r, ld;

        vecs[0]  = '{1, 1, 6'b000101,  1, 0, 0, 1, 0};
        vecs[1]  = '{1, 0, 6'b000000,  1, 0, 0, 1, 0};
        vecs[2]  = '{1, 0, 6'b000000, 33, 5, 0, 1, 0};
        vecs[3]  = '{1, 0, 6'b000000,  1, 0, 0, 0, 1};
        vecs[4]  = '{1, 0, 6'b000000,  1, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 6'b000000,  1, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 6'b000000,  3, 0, 1, 0, 0};
        vecs[7]  = '{1, 0, 6'b000000,  1, 1, 0, 0, 0};
        vecs[8]  = '{1, 0, 6'b000000,  2, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 6'b000000,  6, 2, 1, 0, 0};
        vecs[10] = '{1, 0, 6'b000000,  4, 3, 0, 0, 0};
        vecs[11] = '{1, 1, 6'b000001,  1, 3, 0, 1, 0};
        vecs[12] = '{1, 1, 6'b100000,  1, 3, 0, 1, 0};
        vecs[13] = '{1, 0, 6'b000000, 15, 5, 0, 1, 0};
        vecs[14] = '{1, 0, 6'b000000,  1, 0, 0, 0, 1};
        vecs[15] = '{1, 0, 6'b000000,  2, 0, 0, 0, 0};
        vecs[16] = '{1, 0, 6'b000000, 30, 5, 1, 0, 0};
        vecs[17] = '{1, 0, 6'b000000,  3, 5, 1, 0, 0};
        vecs[18] = '{1, 1, 6'b010000,  1, 0, 0, 0, 1};
        vecs[19] = '{1, 1, 6'b001000,  1, 0, 0, 1, 0};
        vecs[20] = '{1, 0, 6'b000000, 25, 4, 1, 1, 0};
        vecs[21] = '{1, 0, 6'b000000,  6, 5, 0, 1, 0};
        vecs[22] = '{1, 0, 6'b000000,  4, 0, 0, 0, 1};
        vecs[23] = '{1, 0, 6'b000000, 20, 3, 1, 0, 0};
        vecs[24] = '{0, 1, 6'b000010,  1, 0, 0, 1, 0};
        vecs[25] = '{0, 0, 6'b000000,  3, 0, 0, 1, 0};
        vecs[26] = '{1, 0, 6'b000000,  1, 0, 0, 1, 0};
        vecs[27] = '{1, 0, 6'b000000,  1, 0, 0, 1, 0};
        vecs[28] = '{1, 0, 6'b000000, 18, 3, 1, 1, 0};

        rst_n = 1'b0; run = 1'b0; frame_load = 1'b0; frame_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_index",   32'(led_index),  32'd0);
        chk("reset_enable",  32'(led_enable), 32'd0);
        chk("reset_pending", 32'(pending),    32'd0);
        chk("reset_done",    32'(frame_done), 32'd0);
        rst_n = 1'b1;

`ifndef SKIP_DARK_EN
        // Directed frame sequence
        for (int v = 0; v < 29; v++) begin
            for (int k = 0; k < vecs[v].cycles; k++)
                tick(vecs[v].run, (k == 0) ? vecs[v].load : 1'b0, vecs[v].data);
            chk($sformatf("vec%0d_index", v),   32'(led_index),  32'(vecs[v].e_idx));
            chk($sformatf("vec%0d_enable", v),  32'(led_enable), 32'(vecs[v].e_en));
            chk($sformatf("vec%0d_pending", v), 32'(pending),    32'(vecs[v].e_pend));
            chk($sformatf("vec%0d_done", v),    32'(frame_done), 32'(vecs[v].e_done));
        end

        // Asynchronous reset in the middle of a lit dwell
        #2 rst_n = 1'b0;
        #1;
        chk("async_index",   32'(led_index),  32'd0);
        chk("async_enable",  32'(led_enable), 32'd0);
        chk("async_pending", 32'(pending),    32'd0);
        chk("async_done",    32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset frame must be fully dark and wrap after 36 cycles
        lit = 0;
        tick_done = -1;
        for (int k = 1; k <= 36; k++) begin
            tick(1'b1, 1'b0, '0);
            if (led_enable) lit++;
            if (frame_done && tick_done < 0) tick_done = k;
        end
        chk("post_reset_lit_cycles", 32'(lit), 32'd0);
        chk("post_reset_done_cycle", 32'(tick_done), 32'd36);
        chk("post_reset_index", 32'(led_index), 32'd0);
`endif

        // Randomized run against the reference model
        model_on = 1;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 31) != 0);
            near_wrap = (m_cyc == slot_len() - 1) && (m_idx == L - 1);
            ld = ($urandom_range(0, 19) == 0) || (near_wrap && ($urandom_range(0, 1) == 1));
            tick(r, ld, L'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
